// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the MEM stage
package cpu_types_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [5:0] {
        LW = 6'b100011,
        SW = 6'b101011,
        LL = 6'b110000,
        SC = 6'b111000
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/llsc_link_reg.sv
// rtl/llsc_link_reg.sv - LL/SC link register with snoop and store invalidation
module llsc_link_reg #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              setLink,
    input  logic [WORD_W-1:0] setAddr,
    input  logic              clrLink,
    input  logic              snoopInv,
    input  logic [WORD_W-1:0] snoopAddr,
    input  logic [WORD_W-1:0] cmpAddr,
    output logic              linkValid,
    output logic [WORD_W-1:0] linkAddr,
    output logic              cmpMatch
);

    logic snoopKillsLink;
    logic snoopKillsSet;

    assign snoopKillsLink = snoopInv && (snoopAddr[WORD_W-1:2] == linkAddr[WORD_W-1:2]);
    assign snoopKillsSet  = snoopInv && (snoopAddr[WORD_W-1:2] == setAddr[WORD_W-1:2]);
    assign cmpMatch       = linkValid && (cmpAddr[WORD_W-1:2] == linkAddr[WORD_W-1:2]);

    // A snoop only beats a same-cycle LL when it hits the word being linked
    always_ff @(posedge CLK) begin
        if (RST) begin
            linkValid <= 1'b0;
            linkAddr  <= '0;
        end else if (setLink) begin
            linkValid <= ~snoopKillsSet;
            linkAddr  <= setAddr;
        end else if (clrLink || snoopKillsLink) begin
            linkValid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: dcache request, LL/SC, miss counter
module mem_access_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_ren,
    input  logic              ex_wen,
    input  logic [WORD_W-1:0] ex_addr,
    input  logic [WORD_W-1:0] ex_store,
    input  opcode_t           ex_op,
    input  logic              advance,
    input  logic              flush,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] wb_data,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  wait_cycles
);

    mem_state_t        state;
    logic              memReq;
    logic              isSc;
    logic              isLl;
    logic              scFail;
    logic              scFailNow;
    logic              reqActive;
    logic              accessHit;
    logic              linkMatch;
    logic              linkValid;
    logic [WORD_W-1:0] linkAddr;

    assign memReq    = (ex_ren | ex_wen) & ~flush;
    assign isSc      = ex_wen && (ex_op == SC);
    assign isLl      = ex_ren && (ex_op == LL);
    assign scFail    = isSc & ~linkMatch;
    assign reqActive = ~RST & ((state == IDLE) | (state == WAIT)) & memReq & ~scFail;
    assign accessHit = reqActive & dhit;
    assign scFailNow = ~RST & (state == IDLE) & memReq & scFail;

    assign dmemREN   = reqActive & ex_ren;
    assign dmemWEN   = reqActive & ex_wen;
    assign dmemaddr  = reqActive ? {ex_addr[WORD_W-1:2], 2'b00} : '0;
    assign dmemstore = reqActive ? ex_store : '0;
    assign mem_stall = reqActive & ~dhit;

    // Any SC finishing (pass or fail) and any plain store hitting the linked word drop the link
    llsc_link_reg #(.WORD_W(WORD_W)) u_link (
        .CLK       (CLK),
        .RST       (RST),
        .setLink   (accessHit & isLl),
        .setAddr   (ex_addr),
        .clrLink   ((accessHit & ex_wen & (isSc | linkMatch)) | scFailNow),
        .snoopInv  (snoop_inv),
        .snoopAddr (snoop_addr),
        .cmpAddr   (ex_addr),
        .linkValid (linkValid),
        .linkAddr  (linkAddr),
        .cmpMatch  (linkMatch)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            wb_data     <= '0;
            wb_valid    <= 1'b0;
            wait_cycles <= '0;
        end else begin
            if (mem_stall && (wait_cycles != '1)) begin
                wait_cycles <= wait_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (state)
                IDLE: begin
                    if (scFailNow) begin
                        wb_data  <= '0;
                        wb_valid <= 1'b1;
                        state    <= DONE;
                    end else if (reqActive) begin
                        state <= dhit ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!reqActive) begin
                        state <= IDLE;
                    end else if (dhit) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (flush || advance) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Plain stores leave wb_data untouched; only loads and SC produce a value
            if (accessHit) begin
                wb_valid <= 1'b1;
                if (ex_ren) begin
                    wb_data <= dmemload;
                end else if (isSc) begin
                    wb_data <= {{(WORD_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    logic unusedLink;
    assign unusedLink = linkValid ^ (^linkAddr);

endmodule
